// File: rtl/m1_memory_unit.sv
// Word-wide RAM behind a req/ready/ack handshake with byte-lane write enables
// and a fixed number of wait states per access.
module m1_memory_unit #(
  parameter int WORD_SIZE   = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [WORD_SIZE/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic [WORD_SIZE-1:0]   wdata_i,
  output logic                   ready_o,
  output logic                   ack_o,
  output logic [WORD_SIZE-1:0]   rdata_o
);

  localparam int LANES = WORD_SIZE / 8;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    latWe_q, latWe_d;
  logic [LANES-1:0]        latBe_q, latBe_d;
  logic [ADDR_WIDTH-1:0]   latAddr_q, latAddr_d;
  logic [WORD_SIZE-1:0]    latWdata_q, latWdata_d;
  logic                    ack_q, ack_d;
  logic [WORD_SIZE-1:0]    rdata_q;
  logic                    memWrite;
  logic                    memRead;

  logic [WORD_SIZE-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      latWe_q    <= 1'b0;
      latBe_q    <= '0;
      latAddr_q  <= '0;
      latWdata_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latWe_q    <= latWe_d;
      latBe_q    <= latBe_d;
      latAddr_q  <= latAddr_d;
      latWdata_q <= latWdata_d;
      ack_q      <= ack_d;
    end
  end

  // The access happens on the BUSY edge where the wait counter has run out.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latWe_d    = latWe_q;
    latBe_d    = latBe_q;
    latAddr_d  = latAddr_q;
    latWdata_d = latWdata_q;
    ack_d      = 1'b0;
    memWrite   = 1'b0;
    memRead    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          latWe_d    = we_i;
          latBe_d    = be_i;
          latAddr_d  = addr_i;
          latWdata_d = wdata_i;
          cnt_d      = 8'(WAIT_STATES);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          ack_d    = 1'b1;
          state_d  = IDLE;
          memWrite = latWe_q;
          memRead  = !latWe_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM contents survive reset; reset only suppresses a write landing on that edge.
  always_ff @(posedge clk_i) begin
    if (memWrite && !rst_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (latBe_q[i]) begin
          mem[latAddr_q][8*i +: 8] <= latWdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (memRead) begin
      rdata_q <= mem[latAddr_q];
    end
  end

  assign ready_o = (state_q == IDLE);
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_m1_memory_unit.sv
// Bench for m1_memory_unit: one instance with 2 wait states, one with none,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_m1_memory_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        req   [2];
  logic        we    [2];
  logic [1:0]  be    [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic        readyO [2];
  logic        ackO   [2];
  logic [15:0] rdataO [2];

  int vectors     = 0;
  int miscompares = 0;
  int negCount    = 0;

  m1_memory_unit #(.WORD_SIZE(16), .ADDR_WIDTH(16), .WAIT_STATES(2)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]),
    .ready_o(readyO[0]), .ack_o(ackO[0]), .rdata_o(rdataO[0]));

  m1_memory_unit #(.WORD_SIZE(16), .ADDR_WIDTH(16), .WAIT_STATES(0)) dut1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]),
    .ready_o(readyO[1]), .ack_o(ackO[1]), .rdata_o(rdataO[1]));

  // Transaction-level model: an accepted access completes at a known edge number.
  int          edgeNo = 0;
  bit          mValid [2];
  bit          mBusy [2];
  bit          mAck [2];
  bit          mRdKnown [2];
  logic [15:0] mRdata [2];
  int          mDoneEdge [2];
  bit          mWe [2];
  logic [1:0]  mBe [2];
  logic [15:0] mAddr [2];
  logic [15:0] mWdata [2];
  int          mCompletions [2];
  int          dutAcks [2];
  logic [15:0] memM [int];

  function automatic int wsOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  always @(posedge clk) begin
    edgeNo++;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        mValid[d] = 1'b1;
        mBusy[d] = 1'b0;
        mAck[d] = 1'b0;
        mRdata[d] = 16'h0000;
        mRdKnown[d] = 1'b1;
      end else if (mValid[d]) begin
        mAck[d] = 1'b0;
        if (mBusy[d]) begin
          if (edgeNo == mDoneEdge[d]) begin
            int key;
            logic [15:0] cur;
            key = d * 65536 + int'(mAddr[d]);
            cur = memM.exists(key) ? memM[key] : 16'hxxxx;
            if (mWe[d]) begin
              if (mBe[d][0]) cur[7:0]  = mWdata[d][7:0];
              if (mBe[d][1]) cur[15:8] = mWdata[d][15:8];
              memM[key] = cur;
            end else begin
              mRdata[d]   = cur;
              mRdKnown[d] = !$isunknown(cur);
            end
            mAck[d] = 1'b1;
            mBusy[d] = 1'b0;
            mCompletions[d]++;
          end
        end else if (req[d]) begin
          mWe[d] = we[d];
          mBe[d] = be[d];
          mAddr[d] = addr[d];
          mWdata[d] = wdata[d];
          mDoneEdge[d] = edgeNo + wsOf(d) + 1;
          mBusy[d] = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    end
  endtask

  always @(negedge clk) begin
    negCount++;
    for (int d = 0; d < 2; d++) begin
      if (mValid[d]) begin
        checkOutput("ready", d, 32'(readyO[d]), 32'(!mBusy[d]));
        checkOutput("ack", d, 32'(ackO[d]), 32'(mAck[d]));
        if (mRdKnown[d]) checkOutput("rdata", d, 32'(rdataO[d]), 32'(mRdata[d]));
        if (ackO[d] === 1'b1) dutAcks[d]++;
      end
    end
  end

  // Called at a negedge; returns at the negedge where ack is seen, req still high.
  task automatic applyStimulus(input int d, input bit w, input logic [1:0] b,
                               input logic [15:0] a, input logic [15:0] wd,
                               input bit scramble, output int lat, output int readyLow);
    int guard;
    bit done;
    we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd; req[d] = 1'b1;
    lat = 0; readyLow = 0; guard = 0; done = 1'b0;
    while (readyO[d] !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      miscompares++;
      $display("[TB] FAIL accept_timeout dut%0d: ready never seen high", d);
      return;
    end
    @(posedge clk);
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
      if (scramble && lat == 1) begin
        addr[d] = ~a; wdata[d] = ~wd;
      end
      if (readyO[d] !== 1'b1) readyLow++;
      if (ackO[d] === 1'b1) done = 1'b1;
    end
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL ack_timeout dut%0d: no ack within %0d cycles", d, lat);
    end
    lat = lat - 1;
  endtask

  task automatic idleReq(input int d);
    req[d] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic readCheck(input string name, input int d, input logic [15:0] a,
                           input logic [15:0] exp);
    int lat, rl;
    applyStimulus(d, 1'b0, 2'b00, a, 16'h0000, 1'b0, lat, rl);
    checkOutput(name, d, 32'(rdataO[d]), 32'(exp));
  endtask

  initial begin
    int lat, rl, t0, acks0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; be[d] = 2'b00;
      addr[d] = 16'h0000; wdata[d] = 16'h0000;
    end
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    checkOutput("reset_ready", 0, 32'(readyO[0]), 32'd1);
    checkOutput("reset_ack", 0, 32'(ackO[0]), 32'd0);
    checkOutput("reset_rdata", 1, 32'(rdataO[1]), 32'd0);
    @(negedge clk);

    applyStimulus(0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 1'b0, lat, rl);
    checkOutput("t1_latency", 0, 32'(lat), 32'd3);
    checkOutput("t1_ready_low", 0, 32'(rl), 32'd3);
    readCheck("t1_read", 0, 16'h0010, 16'hBEEF);

    applyStimulus(0, 1'b1, 2'b11, 16'h0020, 16'h1234, 1'b0, lat, rl);
    applyStimulus(0, 1'b1, 2'b01, 16'h0020, 16'hABCD, 1'b0, lat, rl);
    readCheck("t2_low_lane", 0, 16'h0020, 16'h12CD);
    applyStimulus(0, 1'b1, 2'b10, 16'h0020, 16'hABCD, 1'b0, lat, rl);
    readCheck("t2_high_lane", 0, 16'h0020, 16'hABCD);
    idleReq(0);

    acks0 = dutAcks[0];
    applyStimulus(0, 1'b1, 2'b11, 16'hFFAF, 16'h3C3C, 1'b0, lat, rl);
    applyStimulus(0, 1'b1, 2'b11, 16'h0050, 16'h0F0F, 1'b1, lat, rl);
    readCheck("t4_latched", 0, 16'h0050, 16'h0F0F);
    readCheck("t4_untouched", 0, 16'hFFAF, 16'h3C3C);
    idleReq(0);
    checkOutput("t4_ack_count", 0, 32'(dutAcks[0] - acks0), 32'd4);

    applyStimulus(0, 1'b1, 2'b11, 16'hFFFF, 16'h7777, 1'b0, lat, rl);
    readCheck("t6_wrap", 0, 16'hFFFF, 16'h7777);
    applyStimulus(0, 1'b1, 2'b00, 16'hFFFF, 16'h1234, 1'b0, lat, rl);
    checkOutput("t6_be0_ack", 0, 32'(ackO[0]), 32'd1);
    readCheck("t6_be0_keep", 0, 16'hFFFF, 16'h7777);

    applyStimulus(0, 1'b1, 2'b11, 16'h0030, 16'h5555, 1'b0, lat, rl);
    idleReq(0);
    we[0] = 1'b1; be[0] = 2'b11; addr[0] = 16'h0030; wdata[0] = 16'hAAAA; req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    checkOutput("t5_ready", 0, 32'(readyO[0]), 32'd1);
    checkOutput("t5_no_ack", 0, 32'(ackO[0]), 32'd0);
    checkOutput("t5_rdata_cleared", 0, 32'(rdataO[0]), 32'd0);
    @(negedge clk);
    checkOutput("t5_no_late_ack", 0, 32'(ackO[0]), 32'd0);
    readCheck("t5_old_data", 0, 16'h0030, 16'h5555);
    idleReq(0);

    applyStimulus(1, 1'b1, 2'b11, 16'h0040, 16'h1111, 1'b0, lat, rl);
    checkOutput("t3_latency", 1, 32'(lat), 32'd1);
    t0 = negCount;
    readCheck("t3_read1", 1, 16'h0040, 16'h1111);
    checkOutput("t3_gap", 1, 32'(negCount - t0), 32'd2);
    t0 = negCount;
    applyStimulus(1, 1'b1, 2'b11, 16'h0040, 16'h2222, 1'b0, lat, rl);
    checkOutput("t3_gap_w2", 1, 32'(negCount - t0), 32'd2);
    readCheck("t3_read2", 1, 16'h0040, 16'h2222);
    idleReq(1);

    checkOutput("acks_vs_model0", 0, 32'(dutAcks[0]), 32'(mCompletions[0]));
    checkOutput("acks_vs_model1", 1, 32'(dutAcks[1]), 32'(mCompletions[1]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
